pipeline_ctrl: RTL and testbench

//  Central sequencer for the 5-stage pipeline registers (IF_ID, ID_EX, EX_MEM, MEM_WB).

---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 38 +++
 rtl/pipeline_ctrl.sv | 163 ++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared types for the pipeline sequencer
//
// Purpose: state encoding of the pipeline_ctrl halt-drain FSM and the default
// width of its performance counters, shared by the RTL and any state tracker.
package pipeline_ctrl_pkg;

  localparam int PCTRL_CNT_W_DEFAULT = 32;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with asynchronous clear
//
// Purpose: counts cycles in which en is high, sticks at all-ones, never wraps.
// Ports:
//   clk  in  1   clock, rising edge
//   rst  in  1   asynchronous active-high clear to zero
//   en   in  1   count enable
//   cnt  out W   current count
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - pipeline register sequencer with halt drain and perf counters
//
// Purpose: drives every pipeline-register enable/flush, the PC load and the
// instruction fetch request from cache hits, hazards and halt markers; runs the
// RUN -> DRAIN -> HALTED sequence and keeps saturating cycle/stall counters.
// Ports:
//   CLK, RST                        clock; asynchronous active-high reset
//   ihit, dhit                      instruction / data access completed this cycle
//   dmemREN_EX_MEM, dmemWEN_EX_MEM  MEM-stage load / store pending
//   load_use, branch_taken, jump_ID hazard and control-flow inputs
//   halt_EX_MEM, halt_MEM_WB        halt instruction position in the pipe
//   enable_*, flush_*               stage load enables and bubble inserts
//   pc_en, imemREN                  PC load and fetch request
//   halt                            sticky halted flag
//   cycle_cnt, stall_cnt            saturating performance counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = PCTRL_CNT_W_DEFAULT
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_EX_MEM,
  input  logic             dmemWEN_EX_MEM,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             jump_ID,
  input  logic             halt_EX_MEM,
  input  logic             halt_MEM_WB,
  output logic             enable_IF_ID,
  output logic             enable_ID_EX,
  output logic             enable_EX_MEM,
  output logic             enable_MEM_WB,
  output logic             flush_IF_ID,
  output logic             flush_ID_EX,
  output logic             pc_en,
  output logic             imemREN,
  output logic             halt,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  pctrl_state_t state_q, state_d;
  logic         halt_q, halt_d;

  logic mem_req;
  logic back_go;
  logic front_go;

  // The back end waits on the data cache when MEM has an access, otherwise on
  // the fetch; the front end needs both to move.
  assign mem_req  = dmemREN_EX_MEM | dmemWEN_EX_MEM;
  assign back_go  = mem_req ? dhit : ihit;
  assign front_go = ihit & (~mem_req | dhit);

  always_comb begin
    state_d       = state_q;
    enable_IF_ID  = 1'b0;
    enable_ID_EX  = 1'b0;
    enable_EX_MEM = 1'b0;
    enable_MEM_WB = 1'b0;
    flush_IF_ID   = 1'b0;
    flush_ID_EX   = 1'b0;
    pc_en         = 1'b0;
    imemREN       = 1'b0;

    // Outputs are held quiet for as long as reset is asserted.
    if (!RST) begin
      unique case (state_q)
        RUN: begin
          imemREN = 1'b1;
          if (!back_go) begin
            // full freeze: nothing moves
          end else if (branch_taken) begin
            // target load happens even if the fetch missed
            {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 4'b1111;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
            pc_en       = 1'b1;
          end else if (!front_go) begin
            // back end advances, front inserts a bubble and refetches the same PC
            {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 4'b1111;
            flush_IF_ID = 1'b1;
          end else if (load_use) begin
            // hold IF_ID and PC, bubble into ID_EX
            {enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 3'b111;
            flush_ID_EX = 1'b1;
          end else if (jump_ID) begin
            {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 4'b1111;
            flush_IF_ID = 1'b1;
            pc_en       = 1'b1;
          end else begin
            {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 4'b1111;
            pc_en = 1'b1;
          end

          if (halt_MEM_WB) begin
            state_d = HALTED;
          end else if (halt_EX_MEM && back_go) begin
            state_d = DRAIN;
          end
        end

        DRAIN: begin
          // no more fetching; bubbles chase the halt down the pipe
          if (back_go) begin
            {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB} = 4'b1111;
            flush_IF_ID = 1'b1;
            flush_ID_EX = 1'b1;
          end
          if (halt_MEM_WB) begin
            state_d = HALTED;
          end
        end

        HALTED: begin
          // only reset leaves this state
        end

        default: begin
          state_d = RUN;
        end
      endcase
    end

    halt_d = (state_d == HALTED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= RUN;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      halt_q  <= halt_d;
    end
  end

  assign halt = halt_q;

  logic cycle_en;
  logic stall_en;

  assign cycle_en = (state_q != HALTED);
  assign stall_en = (state_q != HALTED) & (~enable_IF_ID | flush_IF_ID);

  sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (CLK),
    .rst (RST),
    .en  (cycle_en),
    .cnt (cycle_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (CLK),
    .rst (RST),
    .en  (stall_en),
    .cnt (stall_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          CLK;
  logic          RST;
  logic          ihit, dhit, dmemREN_EX_MEM, dmemWEN_EX_MEM;
  logic          load_use, branch_taken, jump_ID, halt_EX_MEM, halt_MEM_WB;
  logic          enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB;
  logic          flush_IF_ID, flush_ID_EX, pc_en, imemREN, halt;
  logic [CW-1:0] cycle_cnt, stall_cnt;
  logic [7:0]    outs;

  int checks   = 0;
  int failures = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .ihit           (ihit),
    .dhit           (dhit),
    .dmemREN_EX_MEM (dmemREN_EX_MEM),
    .dmemWEN_EX_MEM (dmemWEN_EX_MEM),
    .load_use       (load_use),
    .branch_taken   (branch_taken),
    .jump_ID        (jump_ID),
    .halt_EX_MEM    (halt_EX_MEM),
    .halt_MEM_WB    (halt_MEM_WB),
    .enable_IF_ID   (enable_IF_ID),
    .enable_ID_EX   (enable_ID_EX),
    .enable_EX_MEM  (enable_EX_MEM),
    .enable_MEM_WB  (enable_MEM_WB),
    .flush_IF_ID    (flush_IF_ID),
    .flush_ID_EX    (flush_ID_EX),
    .pc_en          (pc_en),
    .imemREN        (imemREN),
    .halt           (halt),
    .cycle_cnt      (cycle_cnt),
    .stall_cnt      (stall_cnt)
  );

  // {en_IF_ID, en_ID_EX, en_EX_MEM, en_MEM_WB, fl_IF_ID, fl_ID_EX, pc_en, imemREN}
  assign outs = {enable_IF_ID, enable_ID_EX, enable_EX_MEM, enable_MEM_WB,
                 flush_IF_ID, flush_ID_EX, pc_en, imemREN};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic clear_inputs();
    ihit = 0; dhit = 0; dmemREN_EX_MEM = 0; dmemWEN_EX_MEM = 0;
    load_use = 0; branch_taken = 0; jump_ID = 0; halt_EX_MEM = 0; halt_MEM_WB = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    RST = 1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    RST = 1;
    @(negedge CLK);
    #1;
    checks++;
    if (outs !== 8'b0000_0000) begin failures++; $display("FAIL reset_outs got=%b exp=%b", outs, 8'b0000_0000); end
    checks++;
    if (halt !== 1'b0 || cycle_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL reset_state halt=%b cyc=%0d stall=%0d exp 0/0/0", halt, cycle_cnt, stall_cnt);
    end
    @(negedge CLK);
    RST = 0;
    #1;
    checks++;
    if (outs !== 8'b0000_0001) begin failures++; $display("FAIL reset_release_outs got=%b exp=%b", outs, 8'b0000_0001); end
  endtask

  task automatic test_normal();
    int bad;
    do_reset();
    ihit = 1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (outs !== 8'b1111_0011) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL normal_outs bad_cycles=%0d exp=0 last=%b", bad, outs); end
    checks++;
    if (cycle_cnt !== 4'd10) begin failures++; $display("FAIL normal_cycle_cnt got=%0d exp=10", cycle_cnt); end
    checks++;
    if (stall_cnt !== 4'd0) begin failures++; $display("FAIL normal_stall_cnt got=%0d exp=0", stall_cnt); end
  endtask

  task automatic test_mem_stall();
    int bad;
    do_reset();
    dmemREN_EX_MEM = 1; ihit = 1; dhit = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (outs !== 8'b0000_0001) bad++;
      @(negedge CLK);
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL memstall_freeze bad_cycles=%0d exp=0 last=%b", bad, outs); end
    dhit = 1; ihit = 0;
    #1;
    checks++;
    if (outs !== 8'b1111_1001) begin failures++; $display("FAIL memstall_bubble got=%b exp=%b", outs, 8'b1111_1001); end
    @(negedge CLK);
    checks++;
    if (stall_cnt !== 4'd4) begin failures++; $display("FAIL memstall_stall_cnt got=%0d exp=4", stall_cnt); end
    // a pending store stalls the same way as a load
    dmemREN_EX_MEM = 0; dmemWEN_EX_MEM = 1; dhit = 0; ihit = 1;
    #1;
    checks++;
    if (outs !== 8'b0000_0001) begin failures++; $display("FAIL store_freeze got=%b exp=%b", outs, 8'b0000_0001); end
  endtask

  task automatic test_load_use();
    do_reset();
    ihit = 1; load_use = 1;
    #1;
    checks++;
    if (outs !== 8'b0111_0101) begin failures++; $display("FAIL load_use_outs got=%b exp=%b", outs, 8'b0111_0101); end
    @(negedge CLK);
    checks++;
    if (stall_cnt !== 4'd1) begin failures++; $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_cnt); end
  endtask

  task automatic test_branch();
    do_reset();
    ihit = 1; load_use = 1; branch_taken = 1;
    #1;
    checks++;
    if (outs !== 8'b1111_1111) begin failures++; $display("FAIL branch_wins got=%b exp=%b", outs, 8'b1111_1111); end
    // branch target loads even when the fetch side is still waiting
    load_use = 0; dmemREN_EX_MEM = 1; dhit = 1; ihit = 0;
    #1;
    checks++;
    if (outs !== 8'b1111_1111) begin failures++; $display("FAIL branch_no_front got=%b exp=%b", outs, 8'b1111_1111); end
    // but no back_go means freeze regardless of the branch
    dhit = 0;
    #1;
    checks++;
    if (outs !== 8'b0000_0001) begin failures++; $display("FAIL branch_freeze got=%b exp=%b", outs, 8'b0000_0001); end
  endtask

  task automatic test_jump();
    do_reset();
    ihit = 1; jump_ID = 1;
    #1;
    checks++;
    if (outs !== 8'b1111_1011) begin failures++; $display("FAIL jump_outs got=%b exp=%b", outs, 8'b1111_1011); end
    load_use = 1;
    #1;
    checks++;
    if (outs !== 8'b0111_0101) begin failures++; $display("FAIL load_use_over_jump got=%b exp=%b", outs, 8'b0111_0101); end
  endtask

  task automatic test_halt();
    do_reset();
    ihit = 1; halt_EX_MEM = 1;
    @(negedge CLK);
    halt_EX_MEM = 0;
    #1;
    checks++;
    if (outs !== 8'b1111_1100) begin failures++; $display("FAIL drain_outs got=%b exp=%b", outs, 8'b1111_1100); end
    ihit = 0;
    #1;
    checks++;
    if (outs !== 8'b0000_0000) begin failures++; $display("FAIL drain_freeze got=%b exp=%b", outs, 8'b0000_0000); end
    ihit = 1; halt_MEM_WB = 1;
    @(negedge CLK);
    halt_MEM_WB = 0;
    #1;
    checks++;
    if (halt !== 1'b1 || outs !== 8'b0000_0000) begin
      failures++; $display("FAIL halted_entry halt=%b outs=%b exp halt=1 outs=00000000", halt, outs);
    end
    checks++;
    if (cycle_cnt !== 4'd2 || stall_cnt !== 4'd1) begin
      failures++; $display("FAIL halted_counts cyc=%0d stall=%0d exp 2/1", cycle_cnt, stall_cnt);
    end
    for (int i = 0; i < 3; i++) @(negedge CLK);
    #1;
    checks++;
    if (cycle_cnt !== 4'd2 || halt !== 1'b1 || outs !== 8'b0000_0000) begin
      failures++; $display("FAIL halted_frozen cyc=%0d halt=%b outs=%b exp 2/1/00000000", cycle_cnt, halt, outs);
    end
  endtask

  task automatic test_halt_direct();
    do_reset();
    ihit = 1; halt_MEM_WB = 1;
    @(negedge CLK);
    halt_MEM_WB = 0;
    #1;
    checks++;
    if (halt !== 1'b1 || outs !== 8'b0000_0000 || cycle_cnt !== 4'd1) begin
      failures++; $display("FAIL halt_direct halt=%b outs=%b cyc=%0d exp 1/00000000/1", halt, outs, cycle_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    ihit = 1; halt_EX_MEM = 1;
    @(negedge CLK);
    halt_EX_MEM = 0; dmemREN_EX_MEM = 1; dhit = 1;
    #1;
    checks++;
    if (outs !== 8'b1111_1100) begin failures++; $display("FAIL rstmid_drain got=%b exp=%b", outs, 8'b1111_1100); end
    #1;
    RST = 1;
    #1;
    checks++;
    if (outs !== 8'b0000_0000 || halt !== 1'b0 || cycle_cnt !== 4'd0 || stall_cnt !== 4'd0) begin
      failures++; $display("FAIL rstmid_async outs=%b halt=%b cyc=%0d stall=%0d exp 00000000/0/0/0", outs, halt, cycle_cnt, stall_cnt);
    end
    @(negedge CLK);
    RST = 0;
    #1;
    checks++;
    if (outs !== 8'b1111_0011 || cycle_cnt !== 4'd0) begin
      failures++; $display("FAIL rstmid_run outs=%b cyc=%0d exp 11110011/0", outs, cycle_cnt);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 14; i++) @(negedge CLK);
    #1;
    checks++;
    if (stall_cnt !== 4'd14) begin failures++; $display("FAIL sat_pre got=%0d exp=14", stall_cnt); end
    @(negedge CLK);
    #1;
    checks++;
    if (stall_cnt !== 4'd15) begin failures++; $display("FAIL sat_reach got=%0d exp=15", stall_cnt); end
    @(negedge CLK);
    @(negedge CLK);
    #1;
    checks++;
    if (stall_cnt !== 4'd15 || cycle_cnt !== 4'd15) begin
      failures++; $display("FAIL sat_hold stall=%0d cyc=%0d exp 15/15", stall_cnt, cycle_cnt);
    end
  endtask

  initial begin
    RST = 1;
    clear_inputs();
    test_reset();
    test_normal();
    test_mem_stall();
    test_load_use();
    test_branch();
    test_jump();
    test_halt();
    test_halt_direct();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
